// File: rtl/l15_vc_wbb_pkg.sv
// ============================================================================
// Module      : l15_vc_wbb_pkg
// Description : Shared types and default widths for the victim-cache
//               writeback buffer (vc_wbb_match, vc_writeback_buffer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package l15_vc_wbb_pkg;

    localparam int WBB_ADDR_WIDTH = 36;
    localparam int WBB_LINE_WIDTH = 128;
    localparam int WBB_DEPTH      = 4;
    localparam int WBB_DEPTH_LOG2 = 2;

    typedef enum logic [1:0] {
        WBB_FREE = 2'd0,
        WBB_PEND = 2'd1,
        WBB_SENT = 2'd2
    } wbb_state_e;

endpackage

`default_nettype wire

// File: rtl/vc_wbb_match.sv
// ============================================================================
// Module      : vc_wbb_match
// Description : Youngest-priority address matcher over the writeback queue,
//               with a bypass for a push accepted in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_wbb_match
    import l15_vc_wbb_pkg::*;
#(
    parameter int ADDR_WIDTH = WBB_ADDR_WIDTH,
    parameter int DEPTH      = WBB_DEPTH,
    parameter int DEPTH_LOG2 = WBB_DEPTH_LOG2
) (
    input  logic                  lookup_val_i,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    input  wbb_state_e            entry_state_i [DEPTH],
    input  logic [ADDR_WIDTH-1:0] entry_addr_i  [DEPTH],
    input  logic [DEPTH_LOG2-1:0] retire_ptr_i,
    input  logic                  push_val_i,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    input  logic [DEPTH_LOG2-1:0] push_ptr_i,
    output logic                  hit_o,
    output logic [DEPTH_LOG2-1:0] index_o
);

    logic [DEPTH_LOG2-1:0] w_pos;

    // Walk oldest to youngest from retire_ptr so later matches override.
    always_comb begin
        hit_o   = 1'b0;
        index_o = '0;
        w_pos   = '0;
        if (lookup_val_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                w_pos = retire_ptr_i + DEPTH_LOG2'(k);
                if (entry_state_i[w_pos] != WBB_FREE &&
                    entry_addr_i[w_pos] == lookup_addr_i) begin
                    hit_o   = 1'b1;
                    index_o = w_pos;
                end
            end
            if (push_val_i && push_addr_i == lookup_addr_i) begin
                hit_o   = 1'b1;
                index_o = push_ptr_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vc_writeback_buffer.sv
// ============================================================================
// Module      : vc_writeback_buffer
// Description : Holds dirty victim-cache lines until L2 acks their writeback;
//               S1 lookups detect outstanding lines. Define VC_WBB_FWD_EN to
//               add the S2 forwarded-data port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vc_writeback_buffer
    import l15_vc_wbb_pkg::*;
#(
    parameter int ADDR_WIDTH = WBB_ADDR_WIDTH,
    parameter int LINE_WIDTH = WBB_LINE_WIDTH,
    parameter int DEPTH      = WBB_DEPTH,
    parameter int DEPTH_LOG2 = WBB_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vc_wbb_val_s3,
    input  logic [ADDR_WIDTH-1:0] vc_wbb_addr_s3,
    input  logic [LINE_WIDTH-1:0] vc_wbb_data_s3,
    output logic                  wbb_vc_full,
    output logic                  wbb_empty,
    output logic                  wbb_overflow,
    output logic                  wbb_noc_val,
    output logic [ADDR_WIDTH-1:0] wbb_noc_addr,
    output logic [LINE_WIDTH-1:0] wbb_noc_data,
    input  logic                  noc_wbb_rdy,
    input  logic                  noc_wbb_ack,
    input  logic                  l15_wbb_lookup_val_s1,
    input  logic [ADDR_WIDTH-1:0] l15_wbb_lookup_addr_s1,
    output logic                  wbb_l15_hit_s2,
    output logic [DEPTH_LOG2-1:0] wbb_l15_index_s2
`ifdef VC_WBB_FWD_EN
    ,
    output logic [LINE_WIDTH-1:0] wbb_l15_data_s2
`endif
);

    localparam int CW = DEPTH_LOG2 + 1;

    wbb_state_e            state_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
    logic [LINE_WIDTH-1:0] data_q  [DEPTH];

    logic [DEPTH_LOG2-1:0] alloc_ptr_q, issue_ptr_q, retire_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q;
    logic                  hit_q;
    logic [DEPTH_LOG2-1:0] index_q;

    logic                  push_acc, issue_fire, ack_acc;
    logic                  match_hit;
    logic [DEPTH_LOG2-1:0] match_index;

    // Full is taken from the registered count, so a same-cycle ack never
    // makes room for a push.
    assign wbb_vc_full  = (count_q == CW'(DEPTH));
    assign wbb_empty    = (count_q == '0);
    assign wbb_overflow = overflow_q;

    assign push_acc   = vc_wbb_val_s3 && !wbb_vc_full;
    assign wbb_noc_val  = (state_q[issue_ptr_q] == WBB_PEND);
    assign wbb_noc_addr = addr_q[issue_ptr_q];
    assign wbb_noc_data = data_q[issue_ptr_q];
    assign issue_fire = wbb_noc_val && noc_wbb_rdy;
    assign ack_acc    = noc_wbb_ack && (state_q[retire_ptr_q] == WBB_SENT);

    assign count_d = count_q + CW'(push_acc) - CW'(ack_acc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= WBB_FREE;
            end
            alloc_ptr_q  <= '0;
            issue_ptr_q  <= '0;
            retire_ptr_q <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (push_acc) begin
                state_q[alloc_ptr_q] <= WBB_PEND;
                alloc_ptr_q          <= alloc_ptr_q + DEPTH_LOG2'(1);
            end
            if (issue_fire) begin
                state_q[issue_ptr_q] <= WBB_SENT;
                issue_ptr_q          <= issue_ptr_q + DEPTH_LOG2'(1);
            end
            if (ack_acc) begin
                state_q[retire_ptr_q] <= WBB_FREE;
                retire_ptr_q          <= retire_ptr_q + DEPTH_LOG2'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_q | (vc_wbb_val_s3 && wbb_vc_full);
        end
    end

    // Payload storage is qualified by entry state and needs no reset.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            addr_q[alloc_ptr_q] <= vc_wbb_addr_s3;
            data_q[alloc_ptr_q] <= vc_wbb_data_s3;
        end
    end

    vc_wbb_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_match (
        .lookup_val_i  (l15_wbb_lookup_val_s1),
        .lookup_addr_i (l15_wbb_lookup_addr_s1),
        .entry_state_i (state_q),
        .entry_addr_i  (addr_q),
        .retire_ptr_i  (retire_ptr_q),
        .push_val_i    (push_acc),
        .push_addr_i   (vc_wbb_addr_s3),
        .push_ptr_i    (alloc_ptr_q),
        .hit_o         (match_hit),
        .index_o       (match_index)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q   <= 1'b0;
            index_q <= '0;
        end else begin
            hit_q   <= match_hit;
            index_q <= match_index;
        end
    end

    assign wbb_l15_hit_s2   = hit_q;
    assign wbb_l15_index_s2 = index_q;

`ifdef VC_WBB_FWD_EN
    logic [LINE_WIDTH-1:0] fwd_data_q;
    logic [LINE_WIDTH-1:0] fwd_data_d;

    // A same-cycle push is always the youngest match, and its data is not
    // yet in the array.
    always_comb begin
        fwd_data_d = '0;
        if (match_hit) begin
            if (push_acc && vc_wbb_addr_s3 == l15_wbb_lookup_addr_s1) begin
                fwd_data_d = vc_wbb_data_s3;
            end else begin
                fwd_data_d = data_q[match_index];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_data_q <= '0;
        end else begin
            fwd_data_q <= fwd_data_d;
        end
    end

    assign wbb_l15_data_s2 = fwd_data_q;
`else
    // Hit and index only; the L1.5 replays until the entry retires.
`endif

endmodule

`default_nettype wire

// File: tb/tb_vc_writeback_buffer.sv
// ============================================================================
// Module      : tb_vc_writeback_buffer
// Description : Directed self-checking bench for vc_writeback_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vc_writeback_buffer;

    localparam int AW = 36;
    localparam int LW = 128;
    localparam int DL = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push_val;
    logic [AW-1:0] push_addr;
    logic [LW-1:0] push_data;
    logic          full, empty, ovf;
    logic          noc_val;
    logic [AW-1:0] noc_addr;
    logic [LW-1:0] noc_data;
    logic          rdy, ack;
    logic          lk_val;
    logic [AW-1:0] lk_addr;
    logic          hit;
    logic [DL-1:0] idx;
`ifdef VC_WBB_FWD_EN
    logic [LW-1:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [AW-1:0] A = 36'h1_0000_0040;

    always #5 clk = ~clk;

    vc_writeback_buffer dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .vc_wbb_val_s3          (push_val),
        .vc_wbb_addr_s3         (push_addr),
        .vc_wbb_data_s3         (push_data),
        .wbb_vc_full            (full),
        .wbb_empty              (empty),
        .wbb_overflow           (ovf),
        .wbb_noc_val            (noc_val),
        .wbb_noc_addr           (noc_addr),
        .wbb_noc_data           (noc_data),
        .noc_wbb_rdy            (rdy),
        .noc_wbb_ack            (ack),
        .l15_wbb_lookup_val_s1  (lk_val),
        .l15_wbb_lookup_addr_s1 (lk_addr),
        .wbb_l15_hit_s2         (hit),
        .wbb_l15_index_s2       (idx)
`ifdef VC_WBB_FWD_EN
        ,
        .wbb_l15_data_s2        (fwd_data)
`endif
    );

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_val = 1'b0;
        rdy      = 1'b0;
        ack      = 1'b0;
        lk_val   = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] d);
        push_val  = 1'b1;
        push_addr = a;
        push_data = d;
        step();
        push_val  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; push_addr = '0; push_data = '0; lk_addr = '0;
        idle();
        step(); step();
        rst_n = 1'b1;

        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_ovf", ovf, 0);
        check("rst_nocval", noc_val, 0);
        check("rst_hit", hit, 0);
        check("rst_idx", idx, 0);

        // Single line round trip
        push(A, {16{8'hAA}});
        check("t1_nocval", noc_val, 1);
        check("t1_addr", noc_addr, A);
        check("t1_data", noc_data, {16{8'hAA}});
        check("t1_empty", empty, 0);
        rdy = 1'b1; step(); rdy = 1'b0;
        check("t1_sent_val", noc_val, 0);
        check("t1_sent_empty", empty, 0);
        ack = 1'b1; step(); ack = 1'b0;
        check("t1_ack_empty", empty, 1);

        // Stray ack
        ack = 1'b1; step(); ack = 1'b0;
        check("stray_empty", empty, 1);
        check("stray_count", dut.count_q, 0);

        // Fill (entries at indices 1,2,3,0)
        for (int i = 0; i < 4; i++) push(36'h100 + AW'(i), LW'(i + 1));
        check("fill_full", full, 1);
        check("fill_ovf", ovf, 0);
        push(36'h1FF, LW'(9));
        check("ovf_set", ovf, 1);
        check("ovf_full", full, 1);
        check("ovf_count", dut.count_q, 4);

        // Stall stability
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_val", noc_val, 1);
            check("stall_addr", noc_addr, 36'h100);
            check("stall_data", noc_data, LW'(1));
        end
        rdy = 1'b1; step(); rdy = 1'b0;
        check("adv_addr", noc_addr, 36'h101);
        check("adv_data", noc_data, LW'(2));
        check("adv_ptr", dut.issue_ptr_q, 2);

        // Push and ack together while full: push is dropped
        push_val = 1'b1; push_addr = 36'h200; push_data = LW'(7); ack = 1'b1;
        step();
        push_val = 1'b0; ack = 1'b0;
        check("pa_count", dut.count_q, 3);
        check("pa_full", full, 0);
        check("pa_ovf", ovf, 1);
        lk_val = 1'b1; lk_addr = 36'h200; step(); lk_val = 1'b0;
        check("drop_miss", hit, 0);

        // Ack with nothing SENT
        ack = 1'b1; step(); ack = 1'b0;
        check("nosent_count", dut.count_q, 3);
        check("nosent_addr", noc_addr, 36'h101);

        // Lookup over wrapped queue
        lk_val = 1'b1; lk_addr = 36'h102; step(); lk_val = 1'b0;
        check("lk_hit", hit, 1);
        check("lk_idx", idx, 3);
        step();
        check("lk_none_hit", hit, 0);
        check("lk_none_idx", idx, 0);

        // Reset mid-operation
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("mrst_empty", empty, 1);
        check("mrst_ovf", ovf, 0);
        check("mrst_val", noc_val, 0);
        check("mrst_full", full, 0);

        // Lookup bypass on same-cycle push
        lk_val = 1'b1; lk_addr = A;
        push(A, {16{8'h5A}});
        lk_val = 1'b0;
        check("byp_hit", hit, 1);
        check("byp_idx", idx, 0);
`ifdef VC_WBB_FWD_EN
        check("byp_data", fwd_data, {16{8'h5A}});
`endif

        // Youngest duplicate wins
        push(A, {16{8'h11}});
        push(A, {16{8'h22}});
        lk_val = 1'b1; lk_addr = A; step(); lk_val = 1'b0;
        check("young_hit", hit, 1);
        check("young_idx", idx, 2);
`ifdef VC_WBB_FWD_EN
        check("young_data", fwd_data, {16{8'h22}});
`endif
        lk_val = 1'b1; lk_addr = 36'h0_0000_0080; step(); lk_val = 1'b0;
        check("miss_hit", hit, 0);

        // Push, issue and ack in one cycle
        rdy = 1'b1; step(); rdy = 1'b0;
        check("pre3_data", noc_data, {16{8'h11}});
        push_val = 1'b1; push_addr = 36'h300; push_data = LW'(3);
        rdy = 1'b1; ack = 1'b1;
        step();
        idle();
        check("tri_count", dut.count_q, 3);
        check("tri_data", noc_data, {16{8'h22}});
        check("tri_retire", dut.retire_ptr_q, 1);
        check("tri_empty", empty, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
